mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the processor's instruction-fetch port (imem) and data port (dmem).
- Sits between simple processor core and unified memory.
- Registered FSM: one outstanding memory transaction at a time, data-priority with an instruction anti-starvation counter.
- Drives the memory request/ack handshake and returns read data plus a one-cycle ack to the granted requester.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction port, data port and shared memory port.
// The master modport is the arbiter's view; slave is the view of the core and memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  imem_req_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic [DATA_WIDTH-1:0] imem_rdata_o;
    logic                  imem_ack_o;

    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [DATA_WIDTH-1:0] dmem_wdata_i;
    logic [DATA_WIDTH-1:0] dmem_rdata_o;
    logic                  dmem_ack_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    modport master (
        input  imem_req_i, imem_addr_i,
        output imem_rdata_o, imem_ack_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output dmem_rdata_o, dmem_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        output imem_req_i, imem_addr_i,
        input  imem_rdata_o, imem_ack_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_rdata_o, dmem_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports, one transaction
// at a time. Default is data priority with imem anti-starvation; MEM_PORT_ARBITER_RR_EN selects round-robin.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk_i,
    input logic                arst_i,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StAck} state_e;

    state_e state_q, state_d;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] imem_rdata_q, imem_rdata_d;
    logic                  imem_ack_q, imem_ack_d;
    logic [DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;
    logic                  dmem_ack_q, dmem_ack_d;

    logic pick_d;

`ifdef MEM_PORT_ARBITER_RR_EN
    // 0 = imem was granted last, 1 = dmem was granted last
    logic last_grant_q, last_grant_d;

    always_comb begin
        if (bus.imem_req_i && bus.dmem_req_i) begin
            pick_d = !last_grant_q;
        end else begin
            pick_d = bus.dmem_req_i;
        end
    end
`else
    localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(STARVE_LIMIT);

    logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        pick_d = bus.dmem_req_i && !(bus.imem_req_i && (starve_cnt_q == CntMax));
    end
`endif

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        imem_rdata_d = imem_rdata_q;
        imem_ack_d   = imem_ack_q;
        dmem_rdata_d = dmem_rdata_q;
        dmem_ack_d   = dmem_ack_q;
`ifdef MEM_PORT_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    state_d     = StGrantD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dmem_we_i;
                    mem_addr_d  = bus.dmem_addr_i;
                    mem_wdata_d = bus.dmem_wdata_i;
`ifdef MEM_PORT_ARBITER_RR_EN
                    last_grant_d = 1'b1;
`else
                    // Count only data grants that made a waiting fetch wait longer
                    if (bus.imem_req_i && (starve_cnt_q != CntMax)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
`endif
                end else if (bus.imem_req_i) begin
                    state_d     = StGrantI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.imem_addr_i;
                    mem_wdata_d = '0;
`ifdef MEM_PORT_ARBITER_RR_EN
                    last_grant_d = 1'b0;
`else
                    starve_cnt_d = '0;
`endif
                end
            end
            StGrantI: begin
                if (bus.mem_ack_i) begin
                    state_d      = StAck;
                    mem_req_d    = 1'b0;
                    imem_rdata_d = bus.mem_rdata_i;
                    imem_ack_d   = 1'b1;
                end
            end
            StGrantD: begin
                if (bus.mem_ack_i) begin
                    state_d      = StAck;
                    mem_req_d    = 1'b0;
                    dmem_rdata_d = bus.mem_rdata_i;
                    dmem_ack_d   = 1'b1;
                end
            end
            StAck: begin
                state_d    = StIdle;
                imem_ack_d = 1'b0;
                dmem_ack_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset abandons any in-flight transaction; a late mem_ack_i then lands in StIdle
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            imem_rdata_q <= '0;
            imem_ack_q   <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_ack_q   <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_grant_q <= 1'b0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            imem_ack_q   <= imem_ack_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_ack_q   <= dmem_ack_d;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.imem_rdata_o = imem_rdata_q;
    assign bus.imem_ack_o   = imem_ack_q;
    assign bus.dmem_rdata_o = dmem_rdata_q;
    assign bus.dmem_ack_o   = dmem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; a second instance with STARVE_LIMIT=1
// shares the request inputs and always acks immediately.
module tb_mem_port_arbiter;

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 16;
    localparam int          LIMIT  = 4;
    localparam int          LIMIT1 = 1;

    logic clk;
    logic arst;
    logic auto_ack;
    logic mem_ack_v;
    logic [DW-1:0] mem_rdata_v;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT1)) dut1 (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus1)
    );

    assign bus.mem_ack_i   = auto_ack ? bus.mem_req_o : mem_ack_v;
    assign bus.mem_rdata_i = mem_rdata_v;

    assign bus1.imem_req_i   = bus.imem_req_i;
    assign bus1.imem_addr_i  = bus.imem_addr_i;
    assign bus1.dmem_req_i   = bus.dmem_req_i;
    assign bus1.dmem_we_i    = bus.dmem_we_i;
    assign bus1.dmem_addr_i  = bus.dmem_addr_i;
    assign bus1.dmem_wdata_i = bus.dmem_wdata_i;
    assign bus1.mem_ack_i    = bus1.mem_req_o;
    assign bus1.mem_rdata_i  = 16'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".mem_req"},    32'(bus.mem_req_o),    0);
        check({tag, ".mem_we"},     32'(bus.mem_we_o),     0);
        check({tag, ".mem_addr"},   32'(bus.mem_addr_o),   0);
        check({tag, ".mem_wdata"},  32'(bus.mem_wdata_o),  0);
        check({tag, ".imem_ack"},   32'(bus.imem_ack_o),   0);
        check({tag, ".imem_rdata"}, 32'(bus.imem_rdata_o), 0);
        check({tag, ".dmem_ack"},   32'(bus.dmem_ack_o),   0);
        check({tag, ".dmem_rdata"}, 32'(bus.dmem_rdata_o), 0);
    endtask

    task automatic idle_inputs();
        bus.imem_req_i   = 1'b0;
        bus.imem_addr_i  = '0;
        bus.dmem_req_i   = 1'b0;
        bus.dmem_we_i    = 1'b0;
        bus.dmem_addr_i  = '0;
        bus.dmem_wdata_i = '0;
        mem_ack_v        = 1'b0;
        auto_ack         = 1'b0;
    endtask

    // Reference arbitration: streak = data grants made while a fetch waited
    int m_streak;
    bit m_last;

    function automatic bit model_pick_d(input bit pi, input bit pd, input int lim);
`ifdef MEM_PORT_ARBITER_RR_EN
        if (pi && pd) return !m_last;
`else
        if (pi && pd) return (m_streak != lim);
`endif
        return pd;
    endfunction

    function automatic void model_commit(input bit gd, input bit pi, input int lim);
        m_last = gd;
        if (!gd) m_streak = 0;
        else if (pi && m_streak < lim) m_streak = m_streak + 1;
    endfunction

    bit seq4[$];
    bit seq1[$];
    logic [DW-1:0] marr [8];

    initial begin
        bit ip, dp, dwe, prev_i, prev_d, in_grant, gnt_d, ack_pend, ack_who_d;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd, exp_rdata;
        int wait_left;

        arst = 1'b1;
        idle_inputs();
        mem_rdata_v = 16'h0;
        step();
        step();
        check_zero("reset_state");
        arst = 1'b0;

        // Fetch with two wait cycles
        bus.imem_req_i  = 1'b1;
        bus.imem_addr_i = 16'h0040;
        step();
        check("fetch.mem_req", 32'(bus.mem_req_o), 1);
        check("fetch.mem_addr", 32'(bus.mem_addr_o), 32'h40);
        check("fetch.mem_we", 32'(bus.mem_we_o), 0);
        step();
        step();
        check("fetch.hold_req", 32'(bus.mem_req_o), 1);
        check("fetch.hold_addr", 32'(bus.mem_addr_o), 32'h40);
        check("fetch.no_ack_yet", 32'(bus.imem_ack_o), 0);
        mem_ack_v   = 1'b1;
        mem_rdata_v = 16'hA5C3;
        step();
        check("fetch.imem_ack", 32'(bus.imem_ack_o), 1);
        check("fetch.imem_rdata", 32'(bus.imem_rdata_o), 32'hA5C3);
        check("fetch.dmem_ack", 32'(bus.dmem_ack_o), 0);
        check("fetch.req_drop", 32'(bus.mem_req_o), 0);
        mem_ack_v      = 1'b0;
        mem_rdata_v    = 16'h0;
        bus.imem_req_i = 1'b0;
        step();
        check("fetch.ack_pulse", 32'(bus.imem_ack_o), 0);
        check("fetch.rdata_hold", 32'(bus.imem_rdata_o), 32'hA5C3);

        // Write with same-cycle memory ack
        auto_ack         = 1'b1;
        mem_rdata_v      = 16'h0BAD;
        bus.dmem_req_i   = 1'b1;
        bus.dmem_we_i    = 1'b1;
        bus.dmem_addr_i  = 16'h0100;
        bus.dmem_wdata_i = 16'h1234;
        step();
        check("write.mem_req", 32'(bus.mem_req_o), 1);
        check("write.mem_we", 32'(bus.mem_we_o), 1);
        check("write.mem_addr", 32'(bus.mem_addr_o), 32'h100);
        check("write.mem_wdata", 32'(bus.mem_wdata_o), 32'h1234);
        check("write.early_ack", 32'(bus.dmem_ack_o), 0);
        step();
        check("write.dmem_ack", 32'(bus.dmem_ack_o), 1);
        check("write.dmem_rdata", 32'(bus.dmem_rdata_o), 32'h0BAD);
        check("write.imem_ack", 32'(bus.imem_ack_o), 0);
        bus.dmem_req_i = 1'b0;
        auto_ack       = 1'b0;
        step();
        check("write.ack_pulse", 32'(bus.dmem_ack_o), 0);

        // Reset during GRANT_D with random inputs, then a late ack
        bus.dmem_req_i   = 1'b1;
        bus.dmem_we_i    = 1'b1;
        bus.dmem_addr_i  = 16'h0077;
        bus.dmem_wdata_i = 16'hBEEF;
        step();
        check("midrst.granted", 32'(bus.mem_req_o), 1);
        #3;
        bus.imem_req_i   = 1'($urandom);
        bus.imem_addr_i  = 16'($urandom);
        bus.dmem_req_i   = 1'($urandom);
        bus.dmem_we_i    = 1'($urandom);
        bus.dmem_addr_i  = 16'($urandom);
        bus.dmem_wdata_i = 16'($urandom);
        mem_ack_v        = 1'($urandom);
        mem_rdata_v      = 16'($urandom);
        arst             = 1'b1;
        #1;
        check_zero("async_reset");
        step();
        idle_inputs();
        arst      = 1'b0;
        mem_ack_v = 1'b1;
        step();
        check("late_ack.imem", 32'(bus.imem_ack_o), 0);
        check("late_ack.dmem", 32'(bus.dmem_ack_o), 0);
        mem_ack_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_idle", 32'(bus.mem_req_o | bus.imem_ack_o | bus.dmem_ack_o), 0);
        end
        auto_ack        = 1'b1;
        mem_rdata_v     = 16'h5A5A;
        bus.imem_req_i  = 1'b1;
        bus.imem_addr_i = 16'h0022;
        step();
        check("post_reset.mem_addr", 32'(bus.mem_addr_o), 32'h22);
        check("post_reset.mem_we", 32'(bus.mem_we_o), 0);
        step();
        check("post_reset.imem_ack", 32'(bus.imem_ack_o), 1);
        check("post_reset.imem_rdata", 32'(bus.imem_rdata_o), 32'h5A5A);
        idle_inputs();
        step();

        // Contention: both held, immediate acks on both instances
        arst = 1'b1;
        step();
        bus.imem_req_i  = 1'b1;
        bus.imem_addr_i = 16'h0300;
        bus.dmem_req_i  = 1'b1;
        bus.dmem_we_i   = 1'b0;
        bus.dmem_addr_i = 16'h0400;
        auto_ack        = 1'b1;
        arst            = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            check("excl_lim4", 32'(bus.imem_ack_o & bus.dmem_ack_o), 0);
            check("excl_lim1", 32'(bus1.imem_ack_o & bus1.dmem_ack_o), 0);
            if (bus.dmem_ack_o) seq4.push_back(1'b1);
            else if (bus.imem_ack_o) seq4.push_back(1'b0);
            if (bus1.dmem_ack_o) seq1.push_back(1'b1);
            else if (bus1.imem_ack_o) seq1.push_back(1'b0);
        end
        check("order_lim4.count", 32'(seq4.size()), 10);
        check("order_lim1.count", 32'(seq1.size()), 10);
        m_streak = 0;
        m_last   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            gnt_d = model_pick_d(1'b1, 1'b1, LIMIT);
            model_commit(gnt_d, 1'b1, LIMIT);
            check($sformatf("order_lim4[%0d]", k), (k < seq4.size()) ? 32'(seq4[k]) : 32'hFF,
                  32'(gnt_d));
        end
        m_streak = 0;
        m_last   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            gnt_d = model_pick_d(1'b1, 1'b1, LIMIT1);
            model_commit(gnt_d, 1'b1, LIMIT1);
            check($sformatf("order_lim1[%0d]", k), (k < seq1.size()) ? 32'(seq1[k]) : 32'hFF,
                  32'(gnt_d));
        end

        // Randomized traffic against a memory array and reference arbiter
        arst = 1'b1;
        idle_inputs();
        step();
        arst = 1'b0;
        for (int a = 0; a < 8; a++) marr[a] = '0;
        m_streak  = 0;
        m_last    = 1'b0;
        ip        = 0;
        dp        = 0;
        dwe       = 0;
        ia        = '0;
        da        = '0;
        dwd       = '0;
        prev_i    = 0;
        prev_d    = 0;
        in_grant  = 0;
        gnt_d     = 0;
        ack_pend  = 0;
        ack_who_d = 0;
        exp_rdata = '0;
        wait_left = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            step();
            check("rnd.excl", 32'(bus.imem_ack_o & bus.dmem_ack_o), 0);
            if (ack_pend) begin
                check("rnd.imem_ack", 32'(bus.imem_ack_o), 32'(!ack_who_d));
                check("rnd.dmem_ack", 32'(bus.dmem_ack_o), 32'(ack_who_d));
                if (ack_who_d) begin
                    check("rnd.dmem_rdata", 32'(bus.dmem_rdata_o), 32'(exp_rdata));
                    dp = 0;
                end else begin
                    check("rnd.imem_rdata", 32'(bus.imem_rdata_o), 32'(exp_rdata));
                    ip = 0;
                end
                ack_pend = 0;
            end else begin
                check("rnd.no_ack", 32'(bus.imem_ack_o | bus.dmem_ack_o), 0);
            end

            if (bus.mem_req_o && !in_grant) begin
                check("rnd.grant_needs_req", 32'(prev_i | prev_d), 1);
                gnt_d = model_pick_d(prev_i, prev_d, LIMIT);
                model_commit(gnt_d, prev_i, LIMIT);
                check("rnd.mem_addr", 32'(bus.mem_addr_o), gnt_d ? 32'(da) : 32'(ia));
                check("rnd.mem_we", 32'(bus.mem_we_o), gnt_d ? 32'(dwe) : 0);
                check("rnd.mem_wdata", 32'(bus.mem_wdata_o), (gnt_d && dwe) ? 32'(dwd) :
                      (gnt_d ? 32'(dwd) : 0));
                in_grant  = 1;
                wait_left = int'($urandom_range(0, 3));
            end else if (in_grant) begin
                check("rnd.req_held", 32'(bus.mem_req_o), 1);
            end

            mem_ack_v   = 1'b0;
            mem_rdata_v = 16'($urandom);
            if (in_grant) begin
                if (wait_left == 0) begin
                    mem_ack_v = 1'b1;
                    if (gnt_d) begin
                        if (dwe) marr[da[2:0]] = dwd;
                        else mem_rdata_v = marr[da[2:0]];
                    end else begin
                        mem_rdata_v = marr[ia[2:0]];
                    end
                    exp_rdata = mem_rdata_v;
                    ack_who_d = gnt_d;
                    ack_pend  = 1;
                    in_grant  = 0;
                end else begin
                    wait_left--;
                end
            end

            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1;
                ia = 16'($urandom_range(0, 7));
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp  = 1;
                dwe = 1'($urandom);
                da  = 16'($urandom_range(0, 7));
                dwd = 16'($urandom);
            end
            bus.imem_req_i   = ip;
            bus.imem_addr_i  = ia;
            bus.dmem_req_i   = dp;
            bus.dmem_we_i    = dwe;
            bus.dmem_addr_i  = da;
            bus.dmem_wdata_i = dwd;
            prev_i = ip;
            prev_d = dp;
        end

        idle_inputs();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
